// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are captured at start; one partial-product step per clock while BUSY.
module mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             mult_en,
  input  logic [1:0]       mult_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ex_en,
  input  logic             flush,
  output logic             mult_ready,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       fsm_state
);

  localparam int PW = 2 * WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic [1:0]       state;
  logic [PW-1:0]    acc;
  logic [WIDTH-1:0] mcand;
  logic [CNT_W-1:0] cnt;
  logic             neg;
  logic [1:0]       op;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   add_hi;
  logic [PW-1:0]    step_acc;
  logic [PW-1:0]    final_p;

  // Handshake: mult_ready is a level that stays high in DONE until the
  // instruction leaves EX (ex_en) or is squashed (flush); result is valid
  // exactly while mult_ready is high.
  always_comb begin
    a_neg  = ((mult_op == OP_MULH) || (mult_op == OP_MULHSU)) && a[WIDTH-1];
    b_neg  = (mult_op == OP_MULH) && b[WIDTH-1];
    // The negation of the most negative value wraps to itself, which is the
    // correct unsigned magnitude.
    a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
    add_hi = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
    step_acc = {add_hi, acc[WIDTH-1:1]};
    final_p  = neg ? (~step_acc + PW'(1)) : step_acc;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      op     <= '0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
      acc   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mult_en) begin
            op  <= mult_op;
            neg <= a_neg ^ b_neg;
            if ((a == '0) || (b == '0)) begin
              result <= '0;
              state  <= DONE;
            end else begin
              acc   <= {{WIDTH{1'b0}}, b_mag};
              mcand <= a_mag;
              cnt   <= CNT_W'(WIDTH - 1);
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          acc <= step_acc;
          cnt <= cnt - CNT_W'(1);
          // Last step: sign fix-up and word select happen on the same edge.
          if (cnt == '0) begin
            result <= (op == OP_MUL) ? final_p[WIDTH-1:0] : final_p[PW-1:WIDTH];
            state  <= DONE;
          end
        end
        DONE: begin
          if (ex_en) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mult_ready = (state == DONE);
  assign busy       = (state == BUSY);
  assign fsm_state  = state;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: scoreboard of expected products from a
// 66-bit signed reference model, plus latency, hold, flush and reset scenarios.
module tb_mult_unit;

  logic        CLK;
  logic        nRST;
  logic        mult_en;
  logic [1:0]  mult_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        ex_en;
  logic        flush;
  logic        mult_ready;
  logic        busy;
  logic [31:0] result;
  logic [1:0]  fsm_state;

  logic [31:0] exp_q[$];
  logic [31:0] last_exp;
  logic [31:0] exp_v;
  int          n_vec;
  int          n_fail;
  int          cyc;
  logic        ok;

  mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .CLK(CLK), .nRST(nRST), .mult_en(mult_en), .mult_op(mult_op),
    .a(a), .b(b), .ex_en(ex_en), .flush(flush),
    .mult_ready(mult_ready), .busy(busy), .result(result), .fsm_state(fsm_state)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [32:0] sx;
    logic signed [32:0] sy;
    logic signed [65:0] p;
    sx = {((op == 2'b01) || (op == 2'b10)) & x[31], x};
    sy = {(op == 2'b01) & y[31], y};
    p  = sx * sy;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Called at a negedge; returns after the starting posedge with mult_en
  // dropped and operands scrambled (the DUT must ignore them).
  task automatic start_mult(input logic [1:0] op, input logic [31:0] x,
                            input logic [31:0] y, input logic push);
    if (push) exp_q.push_back(model(op, x, y));
    mult_op = op;
    a       = x;
    b       = y;
    mult_en = 1'b1;
    @(posedge CLK);
    #1;
    mult_en = 1'b0;
    a       = $urandom;
    b       = $urandom;
    mult_op = 2'($urandom_range(0, 3));
  endtask

  // Counts edges since the start edge until mult_ready, bounded.
  task automatic wait_ready(output int n, output logic good);
    n    = 0;
    good = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLK);
      n++;
      if (mult_ready) begin
        good = 1'b1;
        break;
      end
    end
  endtask

  task automatic ex_pulse;
    ex_en = 1'b1;
    @(negedge CLK);
    ex_en = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    repeat (3) @(negedge CLK);
    n_vec++;
    if ({mult_ready, busy, result, fsm_state} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset: ready=%b busy=%b result=%h state=%0d, required all zero",
               mult_ready, busy, result, fsm_state);
    end
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_mul_basic;
    start_mult(2'b00, 32'd7, 32'd6, 1'b1);
    wait_ready(cyc, ok);
    exp_v = exp_q.pop_front();
    last_exp = exp_v;
    n_vec++;
    if (!ok || cyc !== 33) begin
      n_fail++;
      $display("FAIL mul_latency: got %0d cycles (ready=%b), required 33", cyc, ok);
    end
    n_vec++;
    if (result !== exp_v) begin
      n_fail++;
      $display("FAIL mul_result: got %h, required %h", result, exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      n_vec++;
      if (mult_ready !== 1'b1 || result !== exp_v) begin
        n_fail++;
        $display("FAIL mul_hold[%0d]: ready=%b result=%h, required 1 %h", i, mult_ready,
                 result, exp_v);
      end
    end
    ex_pulse();
    n_vec++;
    if (mult_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_release: ready=%b, required 0", mult_ready);
    end
  endtask

  task automatic test_signed_ops;
    logic [1:0]  ops[5];
    logic [31:0] xs[5];
    logic [31:0] ys[5];
    ops = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b11};
    xs  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ys  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    for (int i = 0; i < 5; i++) begin
      start_mult(ops[i], xs[i], ys[i], 1'b1);
      wait_ready(cyc, ok);
      exp_v = exp_q.pop_front();
      last_exp = exp_v;
      n_vec++;
      if (!ok || cyc !== 33 || result !== exp_v) begin
        n_fail++;
        $display("FAIL signed_op[%0d]: op=%0d cycles=%0d result=%h, required 33 %h", i,
                 ops[i], cyc, result, exp_v);
      end
      ex_pulse();
    end
    // Spot-check the reference model against hand-derived constants.
    n_vec++;
    if (last_exp !== 32'hFFFFFFFE) begin
      n_fail++;
      $display("FAIL mulhu_const: got %h, required fffffffe", result);
    end
  endtask

  task automatic test_zero;
    logic [1:0]  ops[2];
    logic [31:0] xs[2];
    logic [31:0] ys[2];
    ops = '{2'b00, 2'b11};
    xs  = '{32'h0, 32'd5};
    ys  = '{32'h1234, 32'h0};
    for (int i = 0; i < 2; i++) begin
      start_mult(ops[i], xs[i], ys[i], 1'b1);
      wait_ready(cyc, ok);
      exp_v = exp_q.pop_front();
      last_exp = exp_v;
      n_vec++;
      if (!ok || cyc !== 1 || result !== 32'h0) begin
        n_fail++;
        $display("FAIL zero_early[%0d]: cycles=%0d result=%h, required 1 00000000", i, cyc,
                 result);
      end
      ex_pulse();
      n_vec++;
      if (mult_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_release[%0d]: ready=%b, required 0", i, mult_ready);
      end
    end
  endtask

  task automatic test_flush;
    start_mult(2'b00, 32'h1234, 32'h5678, 1'b0);
    repeat (9) @(negedge CLK);
    n_vec++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_pre_busy: busy=%b, required 1", busy);
    end
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    n_vec++;
    if (fsm_state !== 2'd0 || busy !== 1'b0 || mult_ready !== 1'b0 || result !== last_exp) begin
      n_fail++;
      $display("FAIL flush: state=%0d busy=%b ready=%b result=%h, required 0 0 0 %h",
               fsm_state, busy, mult_ready, result, last_exp);
    end
    start_mult(2'b00, 32'd3, 32'd5, 1'b1);
    wait_ready(cyc, ok);
    exp_v = exp_q.pop_front();
    last_exp = exp_v;
    n_vec++;
    if (!ok || cyc !== 33 || result !== 32'd15) begin
      n_fail++;
      $display("FAIL post_flush: cycles=%0d result=%h, required 33 0000000f", cyc, result);
    end
    ex_pulse();
  endtask

  task automatic test_async_reset;
    start_mult(2'b11, 32'hDEADBEEF, 32'h1234, 1'b0);
    repeat (10) @(negedge CLK);
    #2;
    nRST = 1'b0;
    #1;
    n_vec++;
    if ({mult_ready, busy, result, fsm_state} !== 36'h0) begin
      n_fail++;
      $display("FAIL async_reset: ready=%b busy=%b result=%h state=%0d, required all zero",
               mult_ready, busy, result, fsm_state);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    start_mult(2'b11, 32'h10000, 32'h10000, 1'b1);
    wait_ready(cyc, ok);
    exp_v = exp_q.pop_front();
    last_exp = exp_v;
    n_vec++;
    if (!ok || cyc !== 33 || result !== 32'h1 || exp_v !== 32'h1) begin
      n_fail++;
      $display("FAIL post_reset: cycles=%0d result=%h, required 33 00000001", cyc, result);
    end
    ex_pulse();
  endtask

  task automatic test_back_to_back;
    logic [31:0] x;
    logic [31:0] y;
    logic [1:0]  op;
    for (int i = 0; i < 8; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = (i == 0) ? 32'h80000000 : $urandom;
      y  = (i == 1) ? 32'h7FFFFFFF : $urandom;
      if (x == 0) x = 32'd1;
      if (y == 0) y = 32'd1;
      start_mult(op, x, y, 1'b1);
      wait_ready(cyc, ok);
      exp_v = exp_q.pop_front();
      last_exp = exp_v;
      n_vec++;
      if (!ok || cyc !== 33 || result !== exp_v) begin
        n_fail++;
        $display("FAIL b2b[%0d]: op=%0d a=%h b=%h cycles=%0d result=%h, required 33 %h", i,
                 op, x, y, cyc, result, exp_v);
      end
      ex_pulse();
      n_vec++;
      if (mult_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_stale[%0d]: ready=%b, required 0", i, mult_ready);
      end
    end
  endtask

  initial begin
    n_vec   = 0;
    n_fail  = 0;
    nRST    = 1'b0;
    mult_en = 1'b0;
    mult_op = 2'b00;
    a       = '0;
    b       = '0;
    ex_en   = 1'b0;
    flush   = 1'b0;
    last_exp = '0;
    @(negedge CLK);
    test_reset();
    test_mul_basic();
    test_signed_ops();
    test_zero();
    test_flush();
    test_async_reset();
    test_back_to_back();
    n_vec++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
